input_controller_4out: RTL and testbench



---
 rtl/router_pkg.sv | 22 ++
 rtl/ic_vc_slot.sv | 54 +++++
 rtl/input_controller_4out.sv | 117 +++++++++++
 tb/tb_input_controller_4out.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared flit field positions and route encoding for the router input and output controllers.
package router_pkg;

    localparam int VC_BIT   = 63;
    localparam int DIRX_BIT = 62;
    localparam int DIRY_BIT = 61;
    localparam int HOPX_MSB = 55;
    localparam int HOPX_LSB = 52;
    localparam int HOPY_MSB = 51;
    localparam int HOPY_LSB = 48;
    localparam int HOP_W    = HOPX_MSB - HOPX_LSB + 1;
    localparam int NUM_VC   = 2;
    localparam int NUM_OUT  = 4;

    typedef enum logic [1:0] {
        RT_RIGHT = 2'd0,
        RT_LEFT  = 2'd1,
        RT_VERT  = 2'd2,
        RT_NIC   = 2'd3
    } route_e;

endpackage

// File: rtl/ic_vc_slot.sv
// One-flit virtual-channel slot: holds a flit and its decoded route until popped.
module ic_vc_slot
    import router_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wr_data_i,
    input  route_e        wr_route_i,
    output logic          full_o,
    output logic [DW-1:0] data_o,
    output route_e        route_o
);

    logic          full_q,  full_d;
    logic [DW-1:0] data_q,  data_d;
    route_e        route_q, route_d;

    // Write and pop never hit the same slot in one cycle, so their order here is immaterial.
    always_comb begin
        full_d  = full_q;
        data_d  = data_q;
        route_d = route_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (wr_i) begin
            full_d  = 1'b1;
            data_d  = wr_data_i;
            route_d = wr_route_i;
        end
    end

    // NOTE: the flit storage is reset too, so outputs are defined zeros straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q  <= 1'b0;
            data_q  <= '0;
            route_q <= RT_RIGHT;
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            route_q <= route_d;
        end
    end

    assign full_o  = full_q;
    assign data_o  = data_q;
    assign route_o = route_q;

endmodule

// File: rtl/input_controller_4out.sv
// Router input port: two VC slots, XY route decode, one-of-four output presentation.
// Optional build macro IC_HOP_DEC_EN enables hop-field decrement at write.
module input_controller_4out
    import router_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          polarity,
    input  logic          input_si,
    input  logic [DW-1:0] input_di,
    output logic          input_ri,
    output logic          out0_so,
    output logic [DW-1:0] out0_do,
    input  logic          out0_ri,
    output logic          out1_so,
    output logic [DW-1:0] out1_do,
    input  logic          out1_ri,
    output logic          out2_so,
    output logic [DW-1:0] out2_do,
    input  logic          out2_ri,
    output logic          out3_so,
    output logic [DW-1:0] out3_do,
    input  logic          out3_ri
);

    logic                 in_vc;
    route_e               in_route;
    logic [DW-1:0]        wr_flit;
    logic                 wr_en;
    logic [NUM_VC-1:0]    wr_vc;
    logic [NUM_VC-1:0]    pop_vc;
    logic [NUM_VC-1:0]    slot_full;
    logic [DW-1:0]        slot_data  [NUM_VC];
    route_e               slot_route [NUM_VC];
    logic                 pres_full;
    route_e               pres_route;
    logic [DW-1:0]        pres_data;
    logic [NUM_OUT-1:0]   so_vec;
    logic [NUM_OUT-1:0]   ri_vec;
    logic                 pop;

    assign in_vc = input_di[VC_BIT];

    always_comb begin
        if (input_di[HOPX_MSB:HOPX_LSB] != '0) begin
            in_route = input_di[DIRX_BIT] ? RT_LEFT : RT_RIGHT;
        end else if (input_di[HOPY_MSB:HOPY_LSB] != '0) begin
            in_route = RT_VERT;
        end else begin
            in_route = RT_NIC;
        end
    end

`ifdef IC_HOP_DEC_EN
    // Only the field that selected the route is nonzero-checked, so it never underflows.
    always_comb begin
        wr_flit = input_di;
        case (in_route)
            RT_RIGHT, RT_LEFT: wr_flit[HOPX_MSB:HOPX_LSB] = input_di[HOPX_MSB:HOPX_LSB] - HOP_W'(1);
            RT_VERT:           wr_flit[HOPY_MSB:HOPY_LSB] = input_di[HOPY_MSB:HOPY_LSB] - HOP_W'(1);
            default:           wr_flit = input_di;
        endcase
    end
`else
    assign wr_flit = input_di;
`endif

    assign input_ri = (in_vc != polarity) && !slot_full[in_vc];
    assign wr_en    = input_si && input_ri;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            wr_vc[v]  = wr_en && (in_vc == 1'(v));
            pop_vc[v] = pop && (polarity == 1'(v));
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_slot
        ic_vc_slot #(.DW(DW)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .wr_i       (wr_vc[v]),
            .pop_i      (pop_vc[v]),
            .wr_data_i  (wr_flit),
            .wr_route_i (in_route),
            .full_o     (slot_full[v]),
            .data_o     (slot_data[v]),
            .route_o    (slot_route[v])
        );
    end

    // Only the slot owned by the current timeslot is visible to the outputs.
    assign pres_full  = slot_full[polarity];
    assign pres_route = slot_route[polarity];
    assign pres_data  = slot_data[polarity];

    always_comb begin
        for (int n = 0; n < NUM_OUT; n++) begin
            so_vec[n] = pres_full && (pres_route == route_e'(2'(n)));
        end
    end

    assign ri_vec = {out3_ri, out2_ri, out1_ri, out0_ri};
    assign pop    = |(so_vec & ri_vec);

    assign out0_so = so_vec[0];
    assign out1_so = so_vec[1];
    assign out2_so = so_vec[2];
    assign out3_so = so_vec[3];
    assign out0_do = so_vec[0] ? pres_data : '0;
    assign out1_do = so_vec[1] ? pres_data : '0;
    assign out2_do = so_vec[2] ? pres_data : '0;
    assign out3_do = so_vec[3] ? pres_data : '0;

endmodule

// File: tb/tb_input_controller_4out.sv
// Self-checking bench for input_controller_4out against a per-VC queue model.
module tb_input_controller_4out;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        input_si;
    logic [63:0] input_di;
    logic        input_ri;
    logic        out0_so, out1_so, out2_so, out3_so;
    logic [63:0] out0_do, out1_do, out2_do, out3_do;
    logic [3:0]  ri_v;
    logic [3:0]  so_v;
    logic [63:0] do_v [4];

    int checks = 0;
    int errors = 0;
    int obs_acc = 0;
    int obs_pop = 0;

    logic [63:0] vcq [2][$];

    logic        e_ri;
    logic [3:0]  e_so;
    logic [63:0] e_do [4];

    always #5 clk = ~clk;

    input_controller_4out #(.DW(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .input_si (input_si),
        .input_di (input_di),
        .input_ri (input_ri),
        .out0_so  (out0_so), .out0_do (out0_do), .out0_ri (ri_v[0]),
        .out1_so  (out1_so), .out1_do (out1_do), .out1_ri (ri_v[1]),
        .out2_so  (out2_so), .out2_do (out2_do), .out2_ri (ri_v[2]),
        .out3_so  (out3_so), .out3_do (out3_do), .out3_ri (ri_v[3])
    );

    assign so_v    = {out3_so, out2_so, out1_so, out0_so};
    assign do_v[0] = out0_do;
    assign do_v[1] = out1_do;
    assign do_v[2] = out2_do;
    assign do_v[3] = out3_do;

    function automatic int route_of(input logic [63:0] f);
        if (f[55:52] != 0) return f[62] ? 1 : 0;
        if (f[51:48] != 0) return 2;
        return 3;
    endfunction

    function automatic logic [63:0] exp_out(input logic [63:0] f);
`ifdef IC_HOP_DEC_EN
        if (f[55:52] != 0) return f - (64'd1 << 52);
        if (f[51:48] != 0) return f - (64'd1 << 48);
`endif
        return f;
    endfunction

    function automatic logic [63:0] mk(input logic vc, input logic dx, input int hx, input int hy);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[63] = vc;
        f[62] = dx;
        f[55:52] = 4'(hx);
        f[51:48] = 4'(hy);
        return f;
    endfunction

    task automatic drive(input logic pol, input logic si, input logic [63:0] di, input logic [3:0] ri);
        @(negedge clk);
        polarity = pol;
        input_si = si;
        input_di = di;
        ri_v     = ri;
        #1;
    endtask

    task automatic model_expect();
        logic dvc;
        int   r;
        dvc  = input_di[63];
        e_ri = (dvc != polarity) && (vcq[dvc].size() == 0);
        e_so = '0;
        for (int n = 0; n < 4; n++) e_do[n] = '0;
        if (vcq[polarity].size() > 0) begin
            r = route_of(vcq[polarity][0]);
            e_so[r] = 1'b1;
            e_do[r] = exp_out(vcq[polarity][0]);
        end
    endtask

    task automatic advance();
        logic dvc, pol, acc, pp;
        pol = polarity;
        dvc = input_di[63];
        acc = input_si && (dvc != pol) && (vcq[dvc].size() == 0);
        pp  = (vcq[pol].size() > 0) && ri_v[route_of(vcq[pol][0])];
        obs_acc += int'(input_si && input_ri);
        obs_pop += int'(|(so_v & ri_v));
        @(posedge clk);
        if (pp)  void'(vcq[pol].pop_front());
        if (acc) vcq[dvc].push_back(input_di);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        drive(1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'h0);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (so_v[n] !== 1'b0) begin errors++; $display("FAIL reset.so%0d got %b want 0", n, so_v[n]); end
            checks++;
            if (do_v[n] !== 64'd0) begin errors++; $display("FAIL reset.do%0d got %h want 0", n, do_v[n]); end
        end
        checks++;
        if (input_ri !== 1'b1) begin errors++; $display("FAIL reset.ri got %b want 1", input_ri); end
        reset = 1'b0;
    endtask

    task automatic test_route();
        logic [63:0] fl [5];
        fl[0] = mk(1'b0, 1'b1, 3, $urandom_range(0, 15));
        fl[1] = mk(1'b0, 1'b0, 0, 5);
        fl[2] = mk(1'b0, 1'b0, 0, 0);
        fl[3] = mk(1'b0, 1'b0, 2, 7);
        fl[4] = mk(1'b0, 1'b1, 15, 15);
        for (int i = 0; i < 6; i++) begin
            logic pol;
            logic [63:0] f;
            pol = 1'(i % 2);
            f = (i < 5) ? fl[i] : 64'd0;
            f[63] = ~pol;
            drive(pol, i < 5, f, 4'hF);
            model_expect();
            checks++;
            if (input_ri !== e_ri) begin errors++; $display("FAIL route.ri c%0d got %b want %b", i, input_ri, e_ri); end
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (so_v[n] !== e_so[n]) begin errors++; $display("FAIL route.so%0d c%0d got %b want %b", n, i, so_v[n], e_so[n]); end
                checks++;
                if (do_v[n] !== e_do[n]) begin errors++; $display("FAIL route.do%0d c%0d got %h want %h", n, i, do_v[n], e_do[n]); end
            end
            advance();
        end
    endtask

    task automatic test_hold();
        logic [63:0] f1, f2;
        f1 = mk(1'b1, 1'b0, 1, 4);
        f2 = mk(1'b1, 1'b1, 6, 0);
        for (int i = 0; i < 10; i++) begin
            logic pol;
            logic si;
            logic [63:0] f;
            logic [3:0] ri;
            pol = 1'(i % 2);
            si  = (pol == 1'b0);
            f   = (i == 0) ? f1 : f2;
            ri  = (i < 7) ? 4'b1110 : 4'b1111;
            drive(pol, si, f, ri);
            model_expect();
            checks++;
            if (input_ri !== e_ri) begin errors++; $display("FAIL hold.ri c%0d got %b want %b", i, input_ri, e_ri); end
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (so_v[n] !== e_so[n]) begin errors++; $display("FAIL hold.so%0d c%0d got %b want %b", n, i, so_v[n], e_so[n]); end
                checks++;
                if (do_v[n] !== e_do[n]) begin errors++; $display("FAIL hold.do%0d c%0d got %h want %h", n, i, do_v[n], e_do[n]); end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        obs_acc = 0;
        obs_pop = 0;
        for (int i = 0; i < 20; i++) begin
            logic pol;
            logic [63:0] f;
            pol = 1'(i % 2);
            f = mk(~pol, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            drive(pol, 1'b1, f, 4'hF);
            model_expect();
            checks++;
            if (input_ri !== e_ri) begin errors++; $display("FAIL b2b.ri c%0d got %b want %b", i, input_ri, e_ri); end
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (so_v[n] !== e_so[n]) begin errors++; $display("FAIL b2b.so%0d c%0d got %b want %b", n, i, so_v[n], e_so[n]); end
                checks++;
                if (do_v[n] !== e_do[n]) begin errors++; $display("FAIL b2b.do%0d c%0d got %h want %h", n, i, do_v[n], e_do[n]); end
            end
            advance();
        end
        checks++;
        if (obs_acc !== 20) begin errors++; $display("FAIL b2b.writes got %0d want 20", obs_acc); end
        checks++;
        if (obs_pop !== 19) begin errors++; $display("FAIL b2b.pops got %0d want 19", obs_pop); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic pol;
            logic [63:0] f;
            int hx, hy;
            pol = ($urandom_range(0, 3) == 0) ? polarity : ~polarity;
            hx = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
            hy = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
            f = mk(1'($urandom), 1'($urandom), hx, hy);
            drive(pol, 1'($urandom), f, 4'($urandom));
            model_expect();
            checks++;
            if (input_ri !== e_ri) begin errors++; $display("FAIL rand.ri c%0d got %b want %b", i, input_ri, e_ri); end
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (so_v[n] !== e_so[n]) begin errors++; $display("FAIL rand.so%0d c%0d got %b want %b", n, i, so_v[n], e_so[n]); end
                checks++;
                if (do_v[n] !== e_do[n]) begin errors++; $display("FAIL rand.do%0d c%0d got %h want %h", n, i, do_v[n], e_do[n]); end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, mk(1'b1, 1'b0, 0, 3), 4'h0);
        advance();
        drive(1'b1, 1'b1, mk(1'b0, 1'b1, 2, 0), 4'h0);
        advance();
        drive(1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'h0);
        model_expect();
        checks++;
        if (so_v !== e_so) begin errors++; $display("FAIL rstmid.pre_so got %b want %b", so_v, e_so); end
        checks++;
        if (input_ri !== e_ri) begin errors++; $display("FAIL rstmid.pre_ri got %b want %b", input_ri, e_ri); end
        reset = 1'b1;
        #1;
        vcq[0].delete();
        vcq[1].delete();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (so_v[n] !== 1'b0) begin errors++; $display("FAIL rstmid.so%0d got %b want 0", n, so_v[n]); end
            checks++;
            if (do_v[n] !== 64'd0) begin errors++; $display("FAIL rstmid.do%0d got %h want 0", n, do_v[n]); end
        end
        checks++;
        if (input_ri !== 1'b1) begin errors++; $display("FAIL rstmid.ri got %b want 1", input_ri); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 64'd0, 4'hF);
        checks++;
        if (so_v !== 4'b0000) begin errors++; $display("FAIL rstmid.after_so got %b want 0000", so_v); end
        checks++;
        if (input_ri !== 1'b1) begin errors++; $display("FAIL rstmid.after_ri got %b want 1", input_ri); end
    endtask

    initial begin
        polarity = 1'b0;
        input_si = 1'b0;
        input_di = '0;
        ri_v     = '0;
        test_reset();
        test_route();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
